// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: FIFO read port and serial-line signals of the UART drain stage.
// The master modport is the transmitter's view; slave is the FIFO/pad side.
interface uart_tx_drain_if;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    modport master (
        input  tx_en, fifo_empty, fifo_dout,
        output fifo_rd_en, tx, busy, byte_done
    );

    modport slave (
        output tx_en, fifo_empty, fifo_dout,
        input  fifo_rd_en, tx, busy, byte_done
    );
endinterface

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from a standard (non-FWFT) FIFO and sends them as 8N1 on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7 (8E1 frames).
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_drain_if.master bus
);
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift, shift_next;
    logic             tx_q, tx_next;
    logic             rd_q, rd_next;
    logic             done_q, done_next;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_next;
`endif

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            tx_q   <= 1'b1;
            rd_q   <= 1'b0;
            done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            idx    <= idx_next;
            shift  <= shift_next;
            tx_q   <= tx_next;
            rd_q   <= rd_next;
            done_q <= done_next;
`ifdef UART_TX_PARITY_EN
            par_q  <= par_next;
`endif
        end
    end

    // tx is registered, so each bit value is chosen one edge ahead, at the
    // terminal count of the previous bit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        tx_next    = tx_q;
        rd_next    = 1'b0;
        done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next   = par_q;
`endif
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (bus.tx_en && !bus.fifo_empty) begin
                    state_next = FETCH;
                    rd_next    = 1'b1;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                shift_next = bus.fifo_dout;
                tx_next    = 1'b0;
                cnt_next   = '0;
                state_next = START;
`ifdef UART_TX_PARITY_EN
                par_next   = ^bus.fifo_dout;
`endif
            end
            START: begin
                cnt_next = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    tx_next    = shift[0];
                    shift_next = {1'b0, shift[7:1]};
                    idx_next   = 3'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                cnt_next = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = par_q;
                        state_next = PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = STOP;
`endif
                    end else begin
                        tx_next    = shift[0];
                        shift_next = {1'b0, shift[7:1]};
                        idx_next   = idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_next = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    tx_next    = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                cnt_next = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    tx_next    = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign bus.fifo_rd_en = rd_q;
    assign bus.tx         = tx_q;
    assign bus.byte_done  = done_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: self-checking bench for uart_tx_drain at CLKS_PER_BIT=4, with a FIFO
// model, a frame-decoding monitor and a byte scoreboard. Honours UART_TX_PARITY_EN.
module tb_uart_tx_drain;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    uart_tx_drain_if bus ();

    uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int         check_count = 0;
    int         error_count = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       fifo_empty_r = 1'b1;
    logic [7:0] fifo_dout_r  = 8'h00;

    assign bus.fifo_empty = fifo_empty_r;
    assign bus.fifo_dout  = fifo_dout_r;

    bit               frame_bits [FRAME_CYC];
    int               mon_idx      = 0;
    bit               mon_active   = 1'b0;
    bit               prev_tx      = 1'b1;
    bit               prev_rd      = 1'b0;
    bit               expect_done  = 1'b0;
    int               idle_run     = 0;
    int               frames_seen  = 0;
    int               done_seen    = 0;
    int               pops_seen    = 0;
    int               gap_checks   = 0;
    bit               b2b_mode     = 1'b0;
    int               b2b_base     = 0;
    logic [NBITS-1:0] last_frame   = '0;
    logic [NBITS-1:0] fb;
    logic [7:0]       exp_b;
    bit               glitch;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit expect_sent);
        fifo_q.push_back(data);
        if (expect_sent) exp_q.push_back(data);
    endtask

    function automatic logic [NBITS-1:0] mkFrame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic waitRd(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.fifo_rd_en && n < budget);
        checkOutput("rd_en_seen", bus.fifo_rd_en, 1);
    endtask

    task automatic waitDone(input int count, input int budget);
        int n = 0;
        int target = done_seen + count;
        while (done_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("byte_done_seen", done_seen >= target, 1);
    endtask

    // Standard FIFO: a pop seen at an edge presents its data after that edge.
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            checkOutput("pop_nonempty", fifo_q.size() > 0, 1);
            if (fifo_q.size() > 0) fifo_dout_r <= fifo_q.pop_front();
        end
        fifo_empty_r <= (fifo_q.size() == 0);
    end

    // Line monitor: captures each frame sample by sample and scores the decoded byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active  = 1'b0;
            prev_tx     = 1'b1;
            prev_rd     = 1'b0;
            expect_done = 1'b0;
            idle_run    = 0;
        end else begin
            if (prev_rd) checkOutput("rd_en_one_cycle", bus.fifo_rd_en, 0);
            if (bus.fifo_rd_en) pops_seen++;
            prev_rd = bus.fifo_rd_en;

            if (expect_done) begin
                checkOutput("byte_done_pulse", bus.byte_done, 1);
                checkOutput("busy_low_at_done", bus.busy, 0);
                expect_done = 1'b0;
            end else begin
                checkOutput("byte_done_quiet", bus.byte_done, 0);
            end
            if (bus.byte_done) done_seen++;

            if (!mon_active) begin
                if (prev_tx && !bus.tx) begin
                    if (b2b_mode && frames_seen > b2b_base) begin
                        checkOutput("b2b_gap_cycles", idle_run, 3);
                        gap_checks++;
                    end
                    mon_active    = 1'b1;
                    frame_bits[0] = 1'b0;
                    mon_idx       = 1;
                end else if (bus.tx) begin
                    idle_run++;
                end
            end else begin
                frame_bits[mon_idx] = bus.tx;
                mon_idx++;
                if (mon_idx == FRAME_CYC) begin
                    glitch = 1'b0;
                    for (int b = 0; b < NBITS; b++) begin
                        fb[b] = frame_bits[b*CPB];
                        for (int s = 1; s < CPB; s++)
                            if (frame_bits[b*CPB+s] != frame_bits[b*CPB]) glitch = 1'b1;
                    end
                    checkOutput("bit_width", glitch, 0);
                    checkOutput("stop_bit", fb[NBITS-1], 1);
                    checkOutput("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        checkOutput("sb_data", fb[8:1], exp_b);
`ifdef UART_TX_PARITY_EN
                        checkOutput("sb_parity", fb[9], ^exp_b);
`endif
                    end
                    last_frame  = fb;
                    frames_seen++;
                    mon_active  = 1'b0;
                    idle_run    = 0;
                    expect_done = 1'b1;
                end
            end
            prev_tx = bus.tx;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", check_count, error_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t             vecs[7];
        int               pops_before;
        int               gaps_before;
        logic [NBITS-1:0] exp_frame;

        // Parity column is worked out by hand from the data byte.
        vecs[0] = '{data: 8'h03, par: 1'b0};
        vecs[1] = '{data: 8'hA5, par: 1'b0};
        vecs[2] = '{data: 8'h07, par: 1'b1};
        vecs[3] = '{data: 8'h55, par: 1'b0};
        vecs[4] = '{data: 8'hFF, par: 1'b0};
        vecs[5] = '{data: 8'h00, par: 1'b0};
        vecs[6] = '{data: 8'h01, par: 1'b1};

        rst_n      = 1'b0;
        bus.tx_en  = 1'b1;
        applyStimulus(8'hF0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("reset_tx", bus.tx, 1);
            checkOutput("reset_rd_en", bus.fifo_rd_en, 0);
            checkOutput("reset_busy", bus.busy, 0);
            checkOutput("reset_byte_done", bus.byte_done, 0);
        end
        checkOutput("reset_no_pop", fifo_q.size(), 1);
        rst_n = 1'b1;

        waitRd(20);
        checkOutput("fetch_busy", bus.busy, 1);
        @(negedge clk);
        checkOutput("load_tx_high", bus.tx, 1);
        checkOutput("load_rd_en_low", bus.fifo_rd_en, 0);
        @(negedge clk);
        checkOutput("start_tx_low", bus.tx, 0);
        waitDone(1, FRAME_CYC + 10);
        checkOutput("single_frame_f0", last_frame, mkFrame(8'hF0));
        checkOutput("single_pops", pops_seen, 1);
        @(negedge clk);
        checkOutput("single_busy_after", bus.busy, 0);

        for (int i = 0; i < 7; i++) begin
            pops_before = pops_seen;
            applyStimulus(vecs[i].data, 1'b1);
            waitDone(1, FRAME_CYC + 20);
`ifdef UART_TX_PARITY_EN
            exp_frame = {1'b1, vecs[i].par, vecs[i].data, 1'b0};
`else
            exp_frame = {1'b1, vecs[i].data, 1'b0};
`endif
            checkOutput("table_frame", last_frame, exp_frame);
            checkOutput("table_pops", pops_seen, pops_before + 1);
            repeat (3) @(negedge clk);
        end

        pops_before = pops_seen;
        gaps_before = gap_checks;
        b2b_base    = frames_seen;
        b2b_mode    = 1'b1;
        applyStimulus(8'hF0, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'hA5, 1'b1);
        waitDone(3, 3 * (FRAME_CYC + 10));
        b2b_mode = 1'b0;
        checkOutput("b2b_pops", pops_seen, pops_before + 3);
        checkOutput("b2b_frames", frames_seen, b2b_base + 3);
        checkOutput("b2b_gap_count", gap_checks - gaps_before, 2);
        checkOutput("b2b_last_frame", last_frame, mkFrame(8'hA5));
        repeat (5) @(negedge clk);

        bus.tx_en   = 1'b0;
        pops_before = pops_seen;
        applyStimulus(8'h55, 1'b1);
        repeat (100) @(negedge clk);
        checkOutput("gated_no_pop", pops_seen, pops_before);
        checkOutput("gated_idle", bus.busy, 0);
        bus.tx_en = 1'b1;
        waitRd(10);
        repeat (19) @(negedge clk);
        checkOutput("gated_mid_d3_busy", bus.busy, 1);
        bus.tx_en = 1'b0;
        applyStimulus(8'h66, 1'b0);
        waitDone(1, FRAME_CYC + 20);
        checkOutput("gated_frame_55", last_frame, mkFrame(8'h55));
        repeat (50) @(negedge clk);
        checkOutput("gated_single_pop", pops_seen, pops_before + 1);
        checkOutput("gated_fifo_kept", fifo_q.size(), 1);
        checkOutput("gated_busy_low", bus.busy, 0);

        pops_before = pops_seen;
        applyStimulus(8'h3C, 1'b1);
        bus.tx_en = 1'b1;
        waitRd(10);
        repeat (19) @(negedge clk);
        checkOutput("arst_pre_busy", bus.busy, 1);
        checkOutput("arst_pre_tx_d3", bus.tx, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_tx_now", bus.tx, 1);
        checkOutput("arst_busy_now", bus.busy, 0);
        checkOutput("arst_rd_en_now", bus.fifo_rd_en, 0);
        checkOutput("arst_done_now", bus.byte_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitRd(10);
        waitDone(1, FRAME_CYC + 20);
        checkOutput("arst_next_frame", last_frame, mkFrame(8'h3C));
        checkOutput("arst_pops", pops_seen, pops_before + 2);
        checkOutput("arst_fifo_drained", fifo_q.size(), 0);
        repeat (5) @(negedge clk);

        checkOutput("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
